// File: rtl/kogge_stone_pipe_addsub_if.sv
// Operand/result handshake bundle for kogge_stone_pipe_addsub.
// The SAT field exists only when KS_SAT_EN is defined.
interface kogge_stone_pipe_addsub_if #(
    parameter int WIDTH = 16
);
    logic             IN_VALID;
    logic             IN_READY;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             CIN;
    logic             SUB;
`ifdef KS_SAT_EN
    logic             SAT;
`endif
    logic             OUT_VALID;
    logic             OUT_READY;
    logic [WIDTH-1:0] Y;
    logic             COUT;
    logic             OVF;

`ifdef KS_SAT_EN
    modport master (
        output IN_VALID, A, B, CIN, SUB, SAT, OUT_READY,
        input  IN_READY, OUT_VALID, Y, COUT, OVF
    );
    modport slave (
        input  IN_VALID, A, B, CIN, SUB, SAT, OUT_READY,
        output IN_READY, OUT_VALID, Y, COUT, OVF
    );
`else
    modport master (
        output IN_VALID, A, B, CIN, SUB, OUT_READY,
        input  IN_READY, OUT_VALID, Y, COUT, OVF
    );
    modport slave (
        input  IN_VALID, A, B, CIN, SUB, OUT_READY,
        output IN_READY, OUT_VALID, Y, COUT, OVF
    );
`endif
endinterface

// File: rtl/kogge_stone_pipe_addsub.sv
// Pipelined Kogge-Stone add/sub with global-stall valid/ready flow control.
// Define KS_SAT_EN to add the SAT input and signed saturation of Y on overflow.
module kogge_stone_pipe_addsub #(
    parameter int WIDTH     = 16,
    parameter int REG_EVERY = 1
) (
    input logic                      CLK,
    input logic                      RST,
    kogge_stone_pipe_addsub_if.slave bus
);
    localparam int NLEV = $clog2(WIDTH);

    // Side-band that travels with every beat: original P is needed for the final XOR.
    typedef struct packed {
        logic             valid;
        logic             cin;
`ifdef KS_SAT_EN
        logic             sat;
`endif
        logic [WIDTH-1:0] p0;
    } side_t;

    logic en;
    logic out_valid_q;

    assign en           = !out_valid_q || bus.OUT_READY;
    assign bus.IN_READY = en;

    // Stage 0: operand conditioning and initial generate/propagate.
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] g0_d, g0_q;
    side_t            s0_d, s0_q;

    // NOTE: every variable gets a default at the top of always_comb so no latch is inferred.
    always_comb begin
        b_eff      = bus.B ^ {WIDTH{bus.SUB}};
        g0_d       = bus.A & b_eff;
        s0_d       = '0;
        s0_d.valid = bus.IN_VALID;
        s0_d.cin   = bus.CIN ^ bus.SUB;
        s0_d.p0    = bus.A ^ b_eff;
`ifdef KS_SAT_EN
        s0_d.sat   = bus.SAT;
`endif
    end

    // NOTE: data registers are reset as well, so Y/COUT/OVF read 0 straight out of reset.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            g0_q <= '0;
            s0_q <= '0;
        end else if (en) begin
            // NOTE: non-blocking so every stage samples its neighbour's pre-edge value.
            g0_q <= g0_d;
            s0_q <= s0_d;
        end
    end

    for (genvar k = 1; k <= NLEV; k++) begin : lvl
        localparam int D        = 1 << (k - 1);
        localparam bit REG_HERE = ((k % REG_EVERY) == 0) || (k == NLEV);

        logic [WIDTH-1:0] g_i, p_i, g_d, p_d, g_o, p_o;
        side_t            side_i, side_o;

        if (k == 1) begin : src
            assign g_i    = g0_q;
            assign p_i    = s0_q.p0;
            assign side_i = s0_q;
        end else begin : src
            assign g_i    = lvl[k-1].g_o;
            assign p_i    = lvl[k-1].p_o;
            assign side_i = lvl[k-1].side_o;
        end

        always_comb begin
            g_d = g_i;
            p_d = p_i;
            for (int i = D; i < WIDTH; i++) begin
                g_d[i] = g_i[i] | (p_i[i] & g_i[i-D]);
                p_d[i] = p_i[i] & p_i[i-D];
            end
        end

        if (REG_HERE) begin : stg
            logic [WIDTH-1:0] g_q, p_q;
            side_t            side_q;

            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    g_q    <= '0;
                    p_q    <= '0;
                    side_q <= '0;
                end else if (en) begin
                    g_q    <= g_d;
                    p_q    <= p_d;
                    side_q <= side_i;
                end
            end

            assign g_o    = g_q;
            assign p_o    = p_q;
            assign side_o = side_q;
        end else begin : stg
            assign g_o    = g_d;
            assign p_o    = p_d;
            assign side_o = side_i;
        end
    end

    // Output stage: carries from the prefix tree, then sum, flags and saturation.
    logic [WIDTH-1:0] gf, pf;
    side_t            sf;
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] y_d, y_q;
    logic             cout_d, cout_q;
    logic             ovf_d, ovf_q;
    logic             out_valid_d;

    assign gf = lvl[NLEV].g_o;
    assign pf = lvl[NLEV].p_o;
    assign sf = lvl[NLEV].side_o;

    always_comb begin
        c    = '0;
        c[0] = sf.cin;
        for (int i = 1; i <= WIDTH; i++) begin
            c[i] = gf[i-1] | (pf[i-1] & sf.cin);
        end
        y_d         = sf.p0 ^ c[WIDTH-1:0];
        cout_d      = c[WIDTH];
        ovf_d       = c[WIDTH] ^ c[WIDTH-1];
        out_valid_d = sf.valid;
`ifdef KS_SAT_EN
        // On overflow both operands share a sign bit, which is exactly the carry-out.
        if (sf.sat && ovf_d) begin
            y_d = cout_d ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            y_q         <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (en) begin
            y_q         <= y_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.OUT_VALID = out_valid_q;
    assign bus.Y         = y_q;
    assign bus.COUT      = cout_q;
    assign bus.OVF       = ovf_q;
endmodule

// File: tb/tb_kogge_stone_pipe_addsub.sv
// Self-checking bench for kogge_stone_pipe_addsub (WIDTH=16, REG_EVERY=1).
// Build with KS_SAT_EN defined to exercise the saturation cases.
module tb_kogge_stone_pipe_addsub;
    localparam int W    = 16;
    localparam int RE   = 1;
    localparam int NLEV = $clog2(W);
    localparam int LAT  = 1 + (NLEV + RE - 1) / RE + 1;

    typedef struct {
        logic [W-1:0] y;
        logic         cout;
        logic         ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    kogge_stone_pipe_addsub_if #(.WIDTH(W)) bus ();
    kogge_stone_pipe_addsub #(.WIDTH(W), .REG_EVERY(RE)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic [W-1:0] y, input logic cout, input logic ovf);
        exp_t e;
        e.y    = y;
        e.cout = cout;
        e.ovf  = ovf;
        return e;
    endfunction

    // Reference: plain integer arithmetic on unsigned and signed views of the operands.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, input logic sub, input logic sat);
        exp_t   e;
        longint ua   = a;
        longint ub   = b;
        longint sa   = $signed(a);
        longint sb   = $signed(b);
        longint ci   = cin ? 1 : 0;
        longint smax = (longint'(1) << (W - 1)) - 1;
        longint smin = -(longint'(1) << (W - 1));
        longint full, sres;
        if (!sub) begin
            full   = ua + ub + ci;
            e.cout = (full >= (longint'(1) << W));
            sres   = sa + sb + ci;
        end else begin
            full   = ua - ub - ci;
            e.cout = (full >= 0);
            sres   = sa - sb - ci;
        end
        e.y   = full[W-1:0];
        e.ovf = (sres > smax) || (sres < smin);
        if (sat && e.ovf) e.y = (sres > 0) ? smax[W-1:0] : smin[W-1:0];
        return e;
    endfunction

    // Output monitor: in-order scoreboard plus hold-stability during back-pressure.
    logic         hold_prev = 1'b0;
    logic [W-1:0] y_prev;
    logic         cout_prev, ovf_prev;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                check("hold_valid", bus.OUT_VALID, 1'b1);
                check("hold_y", bus.Y, y_prev);
                check("hold_cout", bus.COUT, cout_prev);
                check("hold_ovf", bus.OVF, ovf_prev);
            end
            if (bus.OUT_VALID && bus.OUT_READY) begin
                check("beat_expected", exp_q.size() > 0, 1'b1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("y", bus.Y, e.y);
                    check("cout", bus.COUT, e.cout);
                    check("ovf", bus.OVF, e.ovf);
                end
            end
            hold_prev = bus.OUT_VALID && !bus.OUT_READY;
            y_prev    = bus.Y;
            cout_prev = bus.COUT;
            ovf_prev  = bus.OVF;
        end
    end

    task automatic push(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic sub, input exp_t e);
        bit done = 1'b0;
        bus.IN_VALID = 1'b1;
        bus.A        = a;
        bus.B        = b;
        bus.CIN      = cin;
        bus.SUB      = sub;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            done = bus.IN_READY;
            @(posedge clk);
            #1;
        end
        check("accept_timeout", done, 1'b1);
        if (done) exp_q.push_back(e);
        bus.IN_VALID = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int n = 0; n < 100 && exp_q.size() != 0; n++) begin
            @(posedge clk);
            #1;
        end
        check(tag, exp_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [W-1:0] ra[20];
        logic [W-1:0] rb[20];
        logic         rc[20];
        logic         rs[20];
        logic         rsat[20];
        int           cnt;
        int           idx;
        logic         exp_rdy;

        rst           = 1'b1;
        bus.IN_VALID  = 1'b0;
        bus.A         = '0;
        bus.B         = '0;
        bus.CIN       = 1'b0;
        bus.SUB       = 1'b0;
        bus.OUT_READY = 1'b1;
`ifdef KS_SAT_EN
        bus.SAT       = 1'b0;
`endif
        #1;
        check("rst_out_valid", bus.OUT_VALID, 1'b0);
        check("rst_in_ready", bus.IN_READY, 1'b1);
        check("rst_y", bus.Y, '0);
        check("rst_cout", bus.COUT, 1'b0);
        check("rst_ovf", bus.OVF, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // First beat: latency from the accept cycle to OUT_VALID.
        push(16'h1234, 16'h4321, 1'b0, 1'b0, mk(16'h5555, 1'b0, 1'b0));
        cnt = 1;
        while (!bus.OUT_VALID && cnt < 50) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        check("latency", cnt, LAT);
        drain("drain_first");

        // Directed carry, overflow and borrow-chain cases.
        push(16'hFFFF, 16'h0001, 1'b1, 1'b0, mk(16'h0001, 1'b1, 1'b0));
        push(16'h7FFF, 16'h0001, 1'b0, 1'b0, mk(16'h8000, 1'b0, 1'b1));
        push(16'h0005, 16'h0007, 1'b0, 1'b1, mk(16'hFFFE, 1'b0, 1'b0));
        push(16'h0005, 16'h0007, 1'b1, 1'b1, mk(16'hFFFD, 1'b0, 1'b0));
        push(16'h7000, 16'h2000, 1'b0, 1'b0, mk(16'h9000, 1'b0, 1'b1));
        drain("drain_directed");

`ifdef KS_SAT_EN
        bus.SAT = 1'b1;
        push(16'h7000, 16'h2000, 1'b0, 1'b0, mk(16'h7FFF, 1'b0, 1'b1));
        push(16'h8000, 16'h0001, 1'b0, 1'b1, mk(16'h8000, 1'b1, 1'b1));
        bus.SAT = 1'b0;
        push(16'h7000, 16'h2000, 1'b0, 1'b0, mk(16'h9000, 1'b0, 1'b1));
        drain("drain_sat");
`endif

        // 20 back-to-back random beats, OUT_READY low for cycles 3..7.
        for (int i = 0; i < 20; i++) begin
            ra[i]   = W'($urandom);
            rb[i]   = W'($urandom);
            rc[i]   = 1'($urandom);
            rs[i]   = 1'($urandom);
`ifdef KS_SAT_EN
            rsat[i] = 1'($urandom);
`else
            rsat[i] = 1'b0;
`endif
        end
        idx = 0;
        for (int cyc = 0; cyc < 200 && idx < 20; cyc++) begin
            bus.OUT_READY = !(cyc >= 3 && cyc <= 7);
            bus.IN_VALID  = 1'b1;
            bus.A         = ra[idx];
            bus.B         = rb[idx];
            bus.CIN       = rc[idx];
            bus.SUB       = rs[idx];
`ifdef KS_SAT_EN
            bus.SAT       = rsat[idx];
`endif
            exp_rdy = (cyc < 3 || cyc > 7) ? 1'b1 : (cyc < LAT);
            @(negedge clk);
            check("stream_in_ready", bus.IN_READY, exp_rdy);
            check("stream_out_valid", bus.OUT_VALID, cyc >= LAT);
            @(posedge clk);
            #1;
            if (exp_rdy) begin
                exp_q.push_back(model(ra[idx], rb[idx], rc[idx], rs[idx], rsat[idx]));
                idx++;
            end
        end
        check("stream_accepted", idx, 20);
        bus.IN_VALID  = 1'b0;
        bus.OUT_READY = 1'b1;
`ifdef KS_SAT_EN
        bus.SAT       = 1'b0;
`endif
        drain("drain_stream");

        // Reset with three beats in flight: nothing may emerge afterwards.
        push(16'h1111, 16'h2222, 1'b0, 1'b0, mk(16'h3333, 1'b0, 1'b0));
        push(16'h0F0F, 16'h0101, 1'b1, 1'b0, mk(16'h1011, 1'b0, 1'b0));
        push(16'hAAAA, 16'h5555, 1'b0, 1'b1, mk(16'h5555, 1'b1, 1'b1));
        rst = 1'b1;
        #1;
        check("midrst_out_valid", bus.OUT_VALID, 1'b0);
        check("midrst_y", bus.Y, '0);
        check("midrst_in_ready", bus.IN_READY, 1'b1);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (LAT + 6) begin
            @(posedge clk);
            #1;
        end
        check("post_rst_idle", bus.OUT_VALID, 1'b0);

        // One model-checked beat after reset proves the pipe still works.
        push(16'hC000, 16'h4000, 1'b0, 1'b1, model(16'hC000, 16'h4000, 1'b0, 1'b1, 1'b0));
        drain("drain_post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/kogge_stone_pipe_addsub.md
Name: kogge_stone_pipe_addsub

Overview:
- Parametrised, pipelined Kogge-Stone prefix adder/subtractor with a valid/ready handshake on input and output.
- Next generation of the team's 16-bit combinational Kogge-Stone adder, generalised to any power-of-two width with selectable pipeline depth.
- Adds subtract mode, carry/borrow chaining and a signed-overflow flag.
- Sits in the FFT datapath as the butterfly add/sub primitive.

Parameters:
- WIDTH, 16, operand width; power of two, 4..64; NLEV = log2(WIDTH) prefix levels.
- REG_EVERY, 1, pipeline register inserted after every REG_EVERY-th prefix level and always after the last level; 1..NLEV.

Ports:
- CLK  input  1  clock, all state on rising edge.
- RST  input  1  asynchronous, active-high reset.
- IN_VALID  input  1  operand beat present.
- IN_READY  output  1  block accepts beat this cycle.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- CIN  input  1  carry-in (add) / borrow-in (sub).
- SUB  input  1  0 = add, 1 = subtract.
- OUT_VALID  output  1  result beat present.
- OUT_READY  input  1  downstream accepts result.
- Y  output  WIDTH  sum/difference.
- COUT  output  1  carry-out (add) / not-borrow (sub).
- OVF  output  1  signed two's-complement overflow.

Behaviour:
- Operand conditioning: B_eff = B XOR {WIDTH{SUB}}; cin_eff = CIN XOR SUB.
  - SUB=1, CIN=0 gives A-B.
  - SUB=1, CIN=1 gives A-B-1 (borrow chain).
- Stage 0 register captures the initial P = A^B_eff, G = A&B_eff, cin_eff and pipeline valid on an accepted beat (IN_VALID && IN_READY).
- Prefix level k (1..NLEV), span d = 2^(k-1):
  - For i >= d: G' = G_i | (P_i & G_{i-d}); P' = P_i & P_{i-d}.
  - For i < d: P and G pass through unchanged.
- Carries: c0 = cin_eff; c_i = Gpre_{i-1} | (Ppre_{i-1} & cin_eff).
  - Group P, the original P and cin_eff are carried alongside each stage register.
- Output register: Y_i = P_i ^ c_i; COUT = c_WIDTH; OVF = c_WIDTH ^ c_(WIDTH-1).
- Latency from accept to OUT_VALID: 1 + ceil(NLEV/REG_EVERY) + 1 cycles.
  - WIDTH=16: REG_EVERY=1 gives 6; REG_EVERY=2 gives 4; REG_EVERY=4 gives 3.
- Throughput: one beat per cycle when not stalled.
- Flow control is a global stall:
  - en = !OUT_VALID || OUT_READY; IN_READY = en.
  - When en=0, every stage register (data and valid) holds.
  - Bubbles are not compressed.
- Y, COUT and OVF hold stable while OUT_VALID=1 and OUT_READY=0.
- A beat with IN_VALID=0 and en=1 inserts a bubble (valid=0). Data registers may load, but an invalid stage never asserts OUT_VALID.
- Simultaneous accept and output pop in one cycle is legal; both transfers occur.
- Reset:
  - All valid bits go to 0, and all data registers, Y, COUT and OVF go to 0.
  - OUT_VALID=0 and IN_READY=1 immediately after reset asserts.
  - Reset mid-operation discards all in-flight beats with no partial output.
- Arithmetic is modulo 2^WIDTH. COUT and OVF are the only width-overflow indications.

Optional Feature:
- Macro KS_SAT_EN.
- Defined:
  - Extra input SAT (1 bit) is captured at stage 0 with the operands and travels with the beat.
  - If SAT=1 and OVF=1, Y is replaced by the signed limit: 0x7FF..F when the true result is positive (A_msb=0), 0x800..0 when negative.
  - OVF still reports the overflow; COUT is unchanged.
- Not defined: no SAT port; Y always wraps modulo 2^WIDTH.

Test Plan:
- Reset, then WIDTH=16 / REG_EVERY=1, A=0x1234, B=0x4321, CIN=0, SUB=0, OUT_READY=1 -> OUT_VALID on cycle 6 after accept; Y=0x5555, COUT=0, OVF=0.
- A=0xFFFF, B=0x0001, CIN=1, SUB=0 -> Y=0x0001, COUT=1, OVF=0. Then A=0x7FFF, B=0x0001, CIN=0 -> Y=0x8000, OVF=1, COUT=0.
- SUB=1, A=0x0005, B=0x0007, CIN=0 -> Y=0xFFFE, COUT=0. Same operands with CIN=1 -> Y=0xFFFD.
- Back-to-back 20 random beats with OUT_READY held 0 for cycles 3-7:
  - IN_READY=0 during the stall.
  - Y held stable while OUT_VALID=1.
  - All 20 results correct and in order versus the golden model; no loss or duplication.
- Assert RST for 1 cycle with 3 beats in flight -> OUT_VALID=0 and Y=0 at once; no stale beat emerges afterwards.
- KS_SAT_EN, SAT=1: A=0x7000, B=0x2000, add -> Y=0x7FFF, OVF=1. A=0x8000, B=0x0001, SUB=1 -> Y=0x8000, OVF=1. Repeat the first case with SAT=0 -> Y=0x9000.
